// File: rtl/fib_stream_gen.sv
// fib_stream_gen: parametrised Fibonacci term generator with a valid/ready
// output stream. Each accepted start emits F0..F(n_terms-1). The stream
// supports backpressure, reports the index of every term, flags the final
// term, pulses done after a run and raises a sticky overflow flag.
//
// Optional feature (macro FIB_SATURATE_EN): when defined, a sum that carries
// out of WIDTH bits, or that uses an already-wrapped operand, loads all-ones
// instead of the truncated value. When undefined, terms wrap modulo 2^WIDTH.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset (0 = reset)
//   start      request a run; sampled only in IDLE
//   n_terms    number of terms to emit; sampled with start
//   busy       high in RUN and DONE
//   out_valid  term available
//   out_ready  consumer accepts term
//   out_data   current term value
//   out_index  index of current term (F0 = index 0)
//   out_last   current term is the final one of the run
//   done       one-cycle pulse after the last transfer or a zero-length run
//   overflow   sticky; an emitted term exceeded WIDTH bits
//
// State | meaning
// IDLE  | waiting for start
// RUN   | presenting terms on the stream
// DONE  | one-cycle completion pulse, then back to IDLE
module fib_stream_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_wr;
  logic             b_wr;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] n_lat;

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] b_next;
  logic             b_wr_next;

  assign sum_full = {1'b0, a} + {1'b0, b};

  // A wrapped operand means the true sum has also left the WIDTH range,
  // so the flag propagates even when this particular add does not carry.
  always_comb begin
    b_wr_next = sum_full[WIDTH] | a_wr | b_wr;
`ifdef FIB_SATURATE_EN
    b_next = b_wr_next ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    b_next = sum_full[WIDTH-1:0];
`endif
  end

  assign out_data  = a;
  assign out_index = idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      a_wr      <= 1'b0;
      b_wr      <= 1'b0;
      idx       <= '0;
      n_lat     <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (n_terms != '0) begin
              n_lat     <= n_terms;
              a         <= '0;
              b         <= WIDTH'(1);
              a_wr      <= 1'b0;
              b_wr      <= 1'b0;
              idx       <= '0;
              out_valid <= 1'b1;
              out_last  <= (n_terms == CNT_W'(1));
              state     <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        RUN: begin
          if (out_ready) begin
            a    <= b;
            b    <= b_next;
            a_wr <= b_wr;
            b_wr <= b_wr_next;
            idx  <= idx + CNT_W'(1);
            if (a_wr) begin
              overflow <= 1'b1;
            end
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              // Not last means idx <= n_lat-2, so idx+2 cannot wrap.
              out_last <= ((idx + CNT_W'(2)) == n_lat);
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_stream_gen.sv
module tb_fib_stream_gen;
  localparam int W  = 8;
  localparam int CW = 8;
  localparam longint CAP = longint'(1) << 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] n_terms;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_index;
  logic          out_last;
  logic          done;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fib_stream_gen #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_terms   (n_terms),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random.
  // inject_at: pulse start (n_terms=5) while term inject_at is presented.
  // reset_at: pull reset low while term reset_at is presented.
  task automatic do_run(input int n, input int mode, input int inject_at, input int reset_at);
    logic [W-1:0] exp_d[$];
    bit           big[$];
    longint       f0, f1, t;
    int           m0, m1, mt;
    int           i, cyc, ph;
    bit           ov, rdy;

    // Reference: true Fibonacci values (capped) decide overflow, the
    // modulo-2^W recurrence gives the wrapped value.
    f0 = 0; f1 = 1; m0 = 0; m1 = 1;
    for (int k = 0; k < n; k++) begin
      big.push_back(f0 >= (longint'(1) << W));
`ifdef FIB_SATURATE_EN
      exp_d.push_back((f0 >= (longint'(1) << W)) ? {W{1'b1}} : W'(m0));
`else
      exp_d.push_back(W'(m0));
`endif
      t = f0 + f1;
      if (t > CAP) t = CAP;
      f0 = f1;
      f1 = t;
      mt = (m0 + m1) % (1 << W);
      m0 = m1;
      m1 = mt;
    end

    n_terms = CW'(n);
    start   = 1'b1;
    tick;
    start   = 1'b0;
    n_terms = CW'($urandom);

    if (n == 0) begin
      chk("zero_valid", out_valid, 0);
      chk("zero_done", done, 1);
      chk("zero_ovf", overflow, 0);
      chk("zero_busy", busy, 1);
      tick;
      chk("zero_done_end", done, 0);
      chk("zero_busy_end", busy, 0);
      chk("zero_valid_end", out_valid, 0);
      return;
    end

    i = 0; ov = 0; cyc = 0; ph = 0;
    while (i < n && cyc < 8 * n + 50) begin
      chk("valid", out_valid, 1);
      chk("data", out_data, exp_d[i]);
      chk("index", out_index, i);
      chk("last", out_last, (i == n - 1));
      chk("ovf", overflow, ov);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      if (reset_at == i) begin
        reset     = 1'b0;
        out_ready = 1'b1;
        tick;
        reset = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        tick;
        chk("rst_done_after", done, 0);
        chk("rst_valid_after", out_valid, 0);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (ph % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ph++;
      out_ready = rdy;
      start     = (inject_at == i);
      n_terms   = start ? CW'(5) : CW'($urandom);
      tick;
      start = 1'b0;
      cyc++;
      if (rdy) begin
        if (big[i]) ov = 1'b1;
        i++;
      end
    end
    chk("run_complete", i, n);
    chk("done_pulse", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 1);
    chk("done_ovf", overflow, ov);
    out_ready = 1'($urandom);
    tick;
    chk("done_end", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    tick;
    chk("done_single", done, 0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    n_terms   = '0;
    tick;
    tick;
    chk("rst_busy0", busy, 0);
    chk("rst_valid0", out_valid, 0);
    chk("rst_data0", out_data, 0);
    chk("rst_index0", out_index, 0);
    chk("rst_last0", out_last, 0);
    chk("rst_done0", done, 0);
    chk("rst_ovf0", overflow, 0);
    reset = 1'b1;
    tick;

    do_run(10, 0, -1, -1);
    do_run(10, 1, -1, -1);
    do_run(0, 0, -1, -1);

    do_run(15, 0, -1, -1);
    chk("ovf_sticky_idle", overflow, 1);
    do_run(0, 0, -1, -1);

    do_run(15, 2, -1, -1);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("ovf_cleared_by_reset", overflow, 0);
    tick;

    do_run(10, 0, -1, 4);
    do_run(3, 0, -1, -1);

    do_run(10, 2, 3, -1);

    do_run(255, 0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      do_run($urandom_range(0, 40), 2, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fib_stream_gen.md
Name: fib_stream_gen

Overview:
- Parametrised hardware Fibonacci sequence generator with a valid/ready output stream.
- Serves as the golden-value source and traffic generator for processor-level program checks: benches and on-chip monitors compare the processor's stored sequence against this stream.
- Generalises the fixed 32-bit, fixed-length Fibonacci check into configurable width and term count.
- Adds backpressure, per-term indexing, completion signalling and overflow detection.

Parameters:
- WIDTH, 32: data width of each term.
- CNT_W, 8: width of the term-count and index fields; max run length is 2^CNT_W-1 terms.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- start  in  1  request a new run; sampled only in IDLE.
- n_terms  in  CNT_W  number of terms to emit; sampled with start.
- busy  out  1  high in RUN and DONE.
- out_valid  out  1  term available.
- out_ready  in  1  consumer accepts term.
- out_data  out  WIDTH  current term value.
- out_index  out  CNT_W  index of current term (F0 = index 0).
- out_last  out  1  current term is the final one of the run.
- done  out  1  one-cycle pulse after the last transfer, or after a zero-length run.
- overflow  out  1  sticky; an emitted term exceeded WIDTH.

Behaviour:
- Reset (reset==0 at a rising edge) applies regardless of state, including mid-run; the current run is abandoned with no done pulse.
  - Outputs after reset: state=IDLE, busy=0, out_valid=0, out_data=0, out_index=0, out_last=0, done=0, overflow=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with n_terms>0: latch n_terms; a=0, b=1, idx=0; clear wrap flags and overflow; go to RUN.
  - start=1 with n_terms==0: clear overflow; go to DONE; no term is emitted.
- Latency: start is accepted at edge k; out_valid=1 from cycle k+1 with out_data=0 (F0).
- RUN:
  - Outputs: out_valid=1, out_data=a, out_index=idx, out_last=(idx==n_latched-1).
  - A transfer is valid&&ready. On a transfer: a<=b; b<=a+b truncated to WIDTH; idx<=idx+1.
  - If out_last on the transfer: go to DONE.
  - Without a transfer, all outputs hold stable. Data must not change while valid is high and ready is low.
- Wrap tracking:
  - Flag a_wr travels with a; flag b_wr travels with b.
  - The new b_wr = carry-out of a+b OR a_wr OR b_wr.
  - On any transfer with a_wr=1, overflow is set and stays set until the next accepted start.
- DONE: done=1 and out_valid=0 for exactly one cycle; next state IDLE. busy stays high in DONE.
- start while not in IDLE is ignored, and n_terms is not resampled.
- out_ready is ignored when out_valid=0.
- With n_terms=2^CNT_W-1, idx reaches 2^CNT_W-2 and never wraps.

Optional Feature:
- Macro: FIB_SATURATE_EN.
- Defined: when a+b carries out, b is loaded with all-ones instead of the truncated sum. Any later sum involving a saturated operand also yields all-ones. Wrap-flag and overflow semantics are unchanged.
- Undefined: modulo-2^WIDTH wrap as described above.

Test Plan:
- WIDTH=8, n_terms=10, out_ready=1: data 0,1,1,2,3,5,8,13,21,34 on consecutive cycles, indices 0..9.
  - out_last only with 34; done pulses the cycle after; busy falls the cycle after done.
- Same run with out_ready toggled 1,0,0,1,...: sequence is identical; out_data and out_index hold during every stall.
- n_terms=0 with start: no out_valid; done=1 exactly one cycle after start; overflow=0.
- WIDTH=8, n_terms=15, macro undefined: index 13 = 233 with overflow=0; index 14 = 121 with overflow=1 from the cycle after that transfer.
  - Macro defined: index 14 = 255, overflow=1.
- Reset low for one cycle at index 4 mid-run: the next cycle shows out_valid=0, busy=0, overflow=0, and no done pulse.
  - A new start with n_terms=3 then gives 0,1,1.
- start pulsed with n_terms=5 during a 10-term run: ignored; the run completes all 10 terms and gives one done pulse.
